// File: rtl/ioctl_mem_arbiter_if.sv
// rtl/ioctl_mem_arbiter_if.sv - download, CPU, shared-memory and status signals of ioctl_mem_arbiter
interface ioctl_mem_arbiter_if #(
  parameter int ADDR_W = 17
);
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [7:0]        ioctl_index;
  logic              cpu_req;
  logic              cpu_we;
  logic [2:0]        cpu_sel;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_din;
  logic              cpu_ack;
  logic              mem_en;
  logic              mem_we;
  logic [2:0]        mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              core_reset;
  logic              dn_err;
  logic [24:0]       dn_bytes;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    output cpu_req, cpu_we, cpu_sel, cpu_addr, cpu_din,
    input  cpu_ack, mem_en, mem_we, mem_sel, mem_addr, mem_din,
    input  core_reset, dn_err, dn_bytes
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    input  cpu_req, cpu_we, cpu_sel, cpu_addr, cpu_din,
    output cpu_ack, mem_en, mem_we, mem_sel, mem_addr, mem_din,
    output core_reset, dn_err, dn_bytes
  );
endinterface

// File: rtl/ioctl_mem_arbiter.sv
// rtl/ioctl_mem_arbiter.sv - shared ROM/RAM port arbiter between HPS downloads and the CPU
// Optional CPU sharing path enabled by defining IOCTL_ARB_CPU_EN.
module ioctl_mem_arbiter #(
  parameter int ADDR_W      = 17,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                clk_sys,
  input  logic                reset,
  ioctl_mem_arbiter_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DL   = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              dl_prev_q, dl_prev_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [2:0]        mem_sel_q, mem_sel_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_din_q, mem_din_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dn_err_q, dn_err_d;
  logic [24:0]       dn_bytes_q, dn_bytes_d;

  logic [2:0] idx_map;
  logic       addr_ok;
  logic       wr_acc;
  logic       wr_rej;
  logic       dl_rise;
  logic       grant;

  always_comb begin
    idx_map = 3'b000;
    case (bus.ioctl_index)
      8'd0:    idx_map = 3'b001;
      8'd3:    idx_map = 3'b010;
      8'd4:    idx_map = 3'b100;
      default: idx_map = 3'b000;
    endcase
  end

  assign addr_ok = (bus.ioctl_addr >> ADDR_W) == 25'd0;
  assign wr_acc  = bus.ioctl_wr && bus.ioctl_download && (idx_map != 3'b000) && addr_ok;
  assign wr_rej  = bus.ioctl_wr && bus.ioctl_download && !((idx_map != 3'b000) && addr_ok);
  assign dl_rise = bus.ioctl_download && !dl_prev_q;

`ifdef IOCTL_ARB_CPU_EN
  assign grant = (state_q == S_IDLE) && !bus.ioctl_download && bus.cpu_req;
`else
  assign grant = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dl_prev_d = bus.ioctl_download;
    case (state_q)
      S_IDLE: if (bus.ioctl_download) state_d = S_DL;
      S_DL: begin
        if (!bus.ioctl_download) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_INIT;
        end
      end
      S_HOLD: begin
        if (bus.ioctl_download)  state_d = S_DL;
        else if (cnt_q == 8'd0)  state_d = S_IDLE;
        else                     cnt_d   = cnt_q - 8'd1;
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = HOLD_INIT;
      end
    endcase
  end

  // Download traffic is checked first; grant already excludes active downloads.
  always_comb begin
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    mem_sel_d  = 3'b000;
    mem_addr_d = '0;
    mem_din_d  = 8'd0;
    cpu_ack_d  = 1'b0;
    if (wr_acc) begin
      mem_en_d   = 1'b1;
      mem_we_d   = 1'b1;
      mem_sel_d  = idx_map;
      mem_addr_d = bus.ioctl_addr[ADDR_W-1:0];
      mem_din_d  = bus.ioctl_dout;
    end else if (grant) begin
      mem_en_d   = 1'b1;
      mem_we_d   = bus.cpu_we;
      mem_sel_d  = bus.cpu_sel;
      mem_addr_d = bus.cpu_addr;
      mem_din_d  = bus.cpu_din;
      cpu_ack_d  = 1'b1;
    end
  end

  // Clear on the download rising edge happens before a same-cycle byte is counted.
  always_comb begin
    dn_err_d   = dl_rise ? 1'b0  : dn_err_q;
    dn_bytes_d = dl_rise ? 25'd0 : dn_bytes_q;
    if (wr_rej) dn_err_d = 1'b1;
    if (wr_acc && (dn_bytes_d != '1)) dn_bytes_d = dn_bytes_d + 25'd1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_HOLD;
      cnt_q      <= HOLD_INIT;
      dl_prev_q  <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_sel_q  <= 3'b000;
      mem_addr_q <= '0;
      mem_din_q  <= 8'd0;
      cpu_ack_q  <= 1'b0;
      dn_err_q   <= 1'b0;
      dn_bytes_q <= 25'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dl_prev_q  <= dl_prev_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_sel_q  <= mem_sel_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      cpu_ack_q  <= cpu_ack_d;
      dn_err_q   <= dn_err_d;
      dn_bytes_q <= dn_bytes_d;
    end
  end

  assign bus.core_reset = (state_q != S_IDLE);
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_sel    = mem_sel_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_din    = mem_din_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.dn_err     = dn_err_q;
  assign bus.dn_bytes   = dn_bytes_q;
endmodule

// File: doc/ioctl_mem_arbiter.md
# ioctl_mem_arbiter

Owns the single shared ROM/RAM port behind the core's download path. It routes HPS ioctl download bytes for BIOS (index 0), sprite ROM (index 3) and YM music (index 4) into a one-hot memory select. When no download is active, it shares the same port with the running CPU. It also sequences the core reset around downloads and flags bad download traffic.

## Interface
Parameters:
- ADDR_W, 17, width of the shared memory address; download addresses at or above 2^ADDR_W are rejected.
- HOLD_CYCLES, 16, number of clk_sys cycles core_reset stays asserted after ioctl_download falls or reset releases; legal range 1..256.

Ports:
- clk_sys  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  HPS download in progress.
- ioctl_wr  in  1  one-cycle strobe; byte valid.
- ioctl_addr  in  25  download byte address.
- ioctl_dout  in  8  download byte.
- ioctl_index  in  8  download target index.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_sel  in  3  one-hot target: bit0 BIOS, bit1 sprite, bit2 music.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_din  in  8  CPU write data.
- cpu_ack  out  1  one-cycle grant pulse.
- mem_en  out  1  access strobe.
- mem_we  out  1  write strobe; only ever high together with mem_en.
- mem_sel  out  3  one-hot target, same bit map as cpu_sel.
- mem_addr  out  ADDR_W  access address.
- mem_din  out  8  write data.
- core_reset  out  1  reset for the system block.
- dn_err  out  1  sticky download error flag.
- dn_bytes  out  25  bytes accepted in the current or last download.

## Operation
- State machine with three states: IDLE, DL, HOLD. A HOLD counter runs from HOLD_CYCLES-1 down to 0.
- IDLE: if ioctl_download=1, go to DL.
- DL: if ioctl_download=0, go to HOLD and load the counter.
- HOLD: if ioctl_download=1, go to DL. Otherwise, if the counter is 0, go to IDLE; else decrement the counter.
- core_reset is 1 whenever the state is not IDLE. It is decoded directly from the state register.
- Download byte acceptance:
  - A byte is accepted when ioctl_wr=1, ioctl_download=1, the index maps, and ioctl_addr < 2^ADDR_W. This holds regardless of state.
  - Index map: 0 → 3'b001, 3 → 3'b010, 4 → 3'b100. Any other index is unmapped.
  - On acceptance: mem_en=1, mem_we=1, mem_sel=map, mem_addr=ioctl_addr[ADDR_W-1:0], mem_din=ioctl_dout. dn_bytes increments, saturating at 2^25-1.
- Download byte rejection:
  - ioctl_wr=1 during a download with an unmapped index or an out-of-range address causes no memory access and sets dn_err=1.
- Download start: the rising edge of ioctl_download clears dn_err and dn_bytes. If a write arrives in that same edge cycle, it is counted after the clear (dn_bytes=1).
- CPU grant rule:
  - A CPU request is granted only when state=IDLE, ioctl_download=0 and cpu_req=1.
  - On grant: mem_en=1, mem_we=cpu_we, mem_sel=cpu_sel, mem_addr=cpu_addr, mem_din=cpu_din, cpu_ack=1.
  - Read data comes straight from the memory, not through this block.
- In any other condition cpu_req stalls with no ack. Download traffic always wins.
- Reset (any time, including mid-download or mid-HOLD) forces state to HOLD and the counter to HOLD_CYCLES-1. HOLD leaves normally after reset releases.

## Timing
- All outputs are registered.
- Reset values:
  - mem_en=0, mem_we=0, mem_sel=0, mem_addr=0, mem_din=0
  - cpu_ack=0, dn_err=0, dn_bytes=0
  - core_reset=1, because the state is HOLD
- Download write latency: ioctl_wr in cycle N gives the mem strobe in cycle N+1. The strobe lasts one cycle.
- CPU grant latency: a grantable cpu_req in cycle N gives cpu_ack and the mem strobe in cycle N+1. If cpu_req is still high in N+1, it is a new request. This allows one access per cycle back to back.
- Download rising edge in cycle N: core_reset=1 from N+1. A CPU request in cycle N is not granted.
- Download falling edge in cycle N: core_reset falls at N+1+HOLD_CYCLES.
- dn_err updates in the cycle after the offending ioctl_wr.
- dn_bytes updates in the cycle after the accepted ioctl_wr.

## Configuration
- IOCTL_ARB_CPU_EN:
  - Defined: the CPU sharing path operates as described above.
  - Undefined: the cpu_* inputs are ignored, cpu_ack is tied to 0, and the mem port carries only download traffic.
  - All download, reset-sequencing and error behaviour is identical in both builds.

## Test plan
- Release reset with HOLD_CYCLES=16, no download → core_reset=1 for 16 cycles after release, then 0. All other outputs stay at their reset values.
- Download index 3, bytes 0xA5 and 0x5A at addresses 0 and 1 → two mem strobes with mem_sel=3'b010, each in the cycle after its ioctl_wr. dn_bytes=2, dn_err=0. core_reset falls 17 cycles after ioctl_download falls.
- Download index 7, then index 0 at address 0x20000 → no mem strobes, dn_err=1. Starting the next download clears dn_err and dn_bytes to 0.
- IDLE, cpu_req held 3 cycles with cpu_we=1, cpu_sel=3'b100, address 0x1234, data 0x77 → three consecutive cpu_ack pulses and mem writes with those values.
- cpu_req asserted in the same cycle as the ioctl_download rise → no cpu_ack until core_reset has returned to 0. The first grant comes one cycle after IDLE is re-entered.
- Assert reset mid-download after 5 bytes → outputs return to reset values and core_reset=1. The HOLD sequence then restarts.
